fpu_mul_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline wrapper that shares one combinational `fpu_mul` instance among several requesters in the FFT datapath, for example butterfly twiddle multiplications. The block accepts operand pairs over valid/ready channels, registers the granted pair into the multiplier, and registers the product. It returns the product on a single response channel tagged with the requester ID, with full backpressure, at a sustained rate of one multiplication per cycle.

---
 rtl/fpu_mul_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arbiter.sv
// rtl/fpu_mul_arbiter.sv - round-robin arbiter sharing one fpu_mul behind a two-stage pipeline
//
// fpu_mul: combinational IEEE-754 single-precision multiply.
//   a, b : operands
//   p    : product, round-to-nearest-even, subnormal inputs/outputs flushed to signed zero,
//          NaN or Inf*0 gives the canonical quiet NaN 0x7FC00000.
//
// fpu_mul_arbiter: grants one of NUM_REQ operand requesters per cycle, registers the pair
// (S1), multiplies it, registers the product (S2) and presents it tagged with the owner id.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_valid/a/b        : per-requester operand channel (k-th word at [k*SIZE_DATA +: SIZE_DATA])
//   o_req_ready            : one-hot grant, zero when S1 cannot advance or during reset
//   o_rsp_valid/id/data    : response channel driven from S2
//   i_rsp_ready            : consumer accepts the response
//   o_busy                 : either pipeline stage holds a valid entry

module fpu_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic        sa, sb, sign;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic        norm_hi;
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [24:0] sig_r;
  logic signed [9:0] exp_raw, exp_r;
  logic [22:0] frac_out;

  always_comb begin
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    ma = a[22:0];
    mb = b[22:0];
    sign = sa ^ sb;
    // exponent 0 is treated as zero: subnormals are flushed
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    b_nan  = (eb == 8'hFF) && (mb != 23'd0);

    prod = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
    // product of two [1,2) significands lies in [1,4); bit 47 flags the [2,4) case
    norm_hi = prod[47];
    if (norm_hi) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | frac[0]);
    exp_raw  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
             + $signed({9'd0, norm_hi});

    // rounding 1.111...1 up carries into a new leading bit
    sig_r = {2'b01, frac} + {24'd0, round_up};
    if (sig_r[24]) begin
      exp_r    = exp_raw + 10'sd1;
      frac_out = sig_r[23:1];
    end else begin
      exp_r    = exp_raw;
      frac_out = sig_r[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      p = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      p = {sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      p = {sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      p = {sign, 31'd0};
    end else begin
      p = {sign, exp_r[7:0], frac_out};
    end
  end
endmodule

module fpu_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 32,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_rsp_valid,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic [SIZE_DATA-1:0]           o_rsp_data,
  input  logic                           i_rsp_ready,
  output logic                           o_busy
);
  localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic                 s1_valid, s2_valid;
  logic [ID_W-1:0]      s1_id, s2_id;
  logic [SIZE_DATA-1:0] s1_a, s1_b, s2_data;
  logic [ID_W-1:0]      rr_ptr;
  logic [SIZE_DATA-1:0] product;

  logic                 s1_adv, s2_adv;
  logic [2*NUM_REQ-1:0] valid_rot;
  logic                 grant_found;
  logic [ID_W:0]        cand;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      next_ptr;
  logic [SIZE_DATA-1:0] a_sel, b_sel;
  logic                 take;

  assign s2_adv = !s2_valid | i_rsp_ready;
  assign s1_adv = !s1_valid | s2_adv;
  assign take   = s1_adv & grant_found;

  fpu_mul u_fpu_mul (
    .a (s1_a),
    .b (s1_b),
    .p (product)
  );

  // Rotating the doubled valid vector by rr_ptr puts the highest-priority requester at bit 0,
  // so the first set bit gives the offset from rr_ptr to the winner.
  always_comb begin
    valid_rot   = {i_req_valid, i_req_valid} >> rr_ptr;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        cand        = (ID_W+1)'(i) + {1'b0, rr_ptr};
        if (cand >= NREQ_W) begin
          cand = cand - NREQ_W;
        end
        grant_id = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (take && !i_rst) begin
      o_req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        a_sel = i_req_a[i*SIZE_DATA +: SIZE_DATA];
        b_sel = i_req_b[i*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_data  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_id    <= s1_id;
        s2_data  <= product;
      end
      if (s1_adv) begin
        s1_valid <= grant_found;
        if (take) begin
          s1_id  <= grant_id;
          s1_a   <= a_sel;
          s1_b   <= b_sel;
          rr_ptr <= next_ptr;
        end
      end
    end
  end

  assign o_rsp_valid = s2_valid;
  assign o_rsp_id    = s2_id;
  assign o_rsp_data  = s2_data;
  assign o_busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// tb/tb_fpu_mul_arbiter.sv - self-checking bench for fpu_mul_arbiter
module tb_fpu_mul_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   dv;
  logic [N*32-1:0] da, db;
  logic           rr;
  logic [N-1:0]   o_req_ready;
  logic           o_rsp_valid;
  logic [1:0]     o_rsp_id;
  logic [31:0]    o_rsp_data;
  logic           o_busy;

  always #5 clk = ~clk;

  fpu_mul_arbiter #(.NUM_REQ(N), .SIZE_DATA(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (dv),
    .i_req_a     (da),
    .i_req_b     (db),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .i_rsp_ready (rr),
    .o_busy      (o_busy)
  );

  int total = 0;
  int bad   = 0;

  // requester side (bench-owned, copied to DUT pins at the falling edge)
  bit          rq_v[N];
  bit          rq_hold[N];
  logic [31:0] rq_a[N], rq_b[N], rq_p[N];
  bit          rst_v;
  bit          rdy_v;

  // reference: at most two products in flight, one "in the multiplier" and one "on the response port"
  bit          m1_v, m2_v;
  int          m1_id, m2_id;
  logic [31:0] m1_p, m2_p;
  int          m_ptr;
  int          g;
  logic [N-1:0] exp_ready;

  // value n * 2^e as a single-precision word, n a small positive integer
  function automatic logic [31:0] make_float(bit s, int n, int e);
    int p;
    logic [31:0] sh;
    p = 0;
    for (int i = 0; i < 16; i++) if (((n >> i) & 1) == 1) p = i;
    sh = 32'(n) << (23 - p);
    return {s, 8'(p + e + 127), sh[22:0]};
  endfunction

  task automatic set_req(int k, bit sa, int na, int ea, bit sb, int nb, int eb, bit hold);
    rq_v[k]    = 1'b1;
    rq_hold[k] = hold;
    rq_a[k]    = make_float(sa, na, ea);
    rq_b[k]    = make_float(sb, nb, eb);
    rq_p[k]    = make_float(sa ^ sb, na * nb, ea + eb);
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      rq_v[k] = 1'b0;
      rq_hold[k] = 1'b0;
    end
  endtask

  // drive pins, let combinational outputs settle, compute the expected grant
  task automatic settle();
    @(negedge clk);
    rst = rst_v;
    rr  = rdy_v;
    for (int k = 0; k < N; k++) begin
      dv[k] = rq_v[k];
      da[k*32 +: 32] = rq_a[k];
      db[k*32 +: 32] = rq_b[k];
    end
    #1;
    g = -1;
    exp_ready = '0;
    if (!rst_v && (!(m1_v && m2_v) || rdy_v)) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && rq_v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
  endtask

  task automatic tick();
    bit room_out, room_in;
    @(posedge clk);
    if (rst_v) begin
      m1_v = 0; m2_v = 0; m_ptr = 0;
    end else begin
      room_out = !m2_v || rdy_v;
      room_in  = !(m1_v && m2_v) || rdy_v;
      if (room_out) begin
        m2_v = m1_v; m2_id = m1_id; m2_p = m1_p;
      end
      if (room_in) begin
        m1_v = (g >= 0);
        if (g >= 0) begin
          m1_id = g;
          m1_p  = rq_p[g];
          m_ptr = (g + 1) % N;
          if (!rq_hold[g]) rq_v[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_v = 1'b1;
    settle();
    tick();
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 1'b1;
    rdy_v = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 0, 1, 0, 0, 1, 0, 1);
    for (int c = 0; c < 2; c++) begin
      settle();
      if (c == 1) begin
        total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy} !== '0)
          begin bad++; $display("FAIL reset_state got ready=%b v=%b id=%0d d=%h busy=%b want all 0",
                   o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy); end
      end
      tick();
    end
    rst_v = 1'b0;
    settle();
    total++;
    if (o_req_ready !== 4'b0001)
      begin bad++; $display("FAIL reset_first_grant got=%b want=0001", o_req_ready); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    rdy_v = 1'b1;
    set_req(0, 0, 2, 0, 0, 3, 0, 0);
    for (int c = 0; c < 5; c++) begin
      settle();
      total++;
      if ({o_req_ready, o_rsp_valid, o_busy} !== {exp_ready, m2_v, m1_v | m2_v})
        begin bad++; $display("FAIL single_ctl c=%0d got=%b/%b/%b want=%b/%b/%b", c,
                 o_req_ready, o_rsp_valid, o_busy, exp_ready, m2_v, m1_v | m2_v); end
      if (c == 2) begin
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {1'b1, 2'd0, 32'h40C00000})
          begin bad++; $display("FAIL single_rsp got v=%b id=%0d d=%h want v=1 id=0 d=40c00000",
                   o_rsp_valid, o_rsp_id, o_rsp_data); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int nrsp;
    do_reset();
    rdy_v = 1'b1;
    nrsp = 0;
    for (int k = 0; k < N; k++) set_req(k, 0, 1, 0, 0, k + 1, 0, 1);
    for (int c = 0; c < 12; c++) begin
      settle();
      total++;
      if (o_req_ready !== 4'(1 << (c % N)))
        begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, o_req_ready, 4'(1 << (c % N))); end
      if (c >= 2) begin
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {1'b1, 2'(nrsp % N), m2_p})
          begin bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                   c, o_rsp_valid, o_rsp_id, o_rsp_data, nrsp % N, m2_p); end
        nrsp++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_v = 1'b0;
    set_req(1, 0, 3, -1, 0, 3, -1, 0);
    set_req(2, 0, 3, -1, 0, 3, -1, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) set_req(3, 0, 1, 0, 0, 5, 0, 0);
      rdy_v = (c >= 7);
      settle();
      total++;
      if ({o_req_ready, o_rsp_valid, o_busy} !== {exp_ready, m2_v, m1_v | m2_v})
        begin bad++; $display("FAIL bp_ctl c=%0d got=%b/%b/%b want=%b/%b/%b", c,
                 o_req_ready, o_rsp_valid, o_busy, exp_ready, m2_v, m1_v | m2_v); end
      if (m2_v) begin
        total++;
        if ({o_rsp_id, o_rsp_data} !== {2'(m2_id), m2_p})
          begin bad++; $display("FAIL bp_rsp c=%0d got id=%0d d=%h want id=%0d d=%h",
                   c, o_rsp_id, o_rsp_data, m2_id, m2_p); end
      end
      if (c >= 2 && c <= 6) begin
        total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data} !== {4'b0000, 1'b1, 2'd1, 32'h40100000})
          begin bad++; $display("FAIL bp_stall c=%0d got ready=%b v=%b id=%0d d=%h want 0000/1/1/40100000",
                   c, o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data); end
      end
      if (c == 7) begin
        total++;
        if (o_req_ready !== 4'b1000)
          begin bad++; $display("FAIL bp_release_grant got=%b want=1000", o_req_ready); end
      end
      if (c == 8) begin
        total++;
        if ({o_rsp_valid, o_rsp_id} !== {1'b1, 2'd2})
          begin bad++; $display("FAIL bp_second_rsp got v=%b id=%0d want v=1 id=2", o_rsp_valid, o_rsp_id); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] want_g[3];
    want_g[0] = 4'b1000;
    want_g[1] = 4'b0001;
    want_g[2] = 4'b0010;
    do_reset();
    rdy_v = 1'b1;
    set_req(2, 0, 1, 0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin settle(); tick(); end
    set_req(3, 0, 5, 0, 0, 3, 1, 0);
    set_req(0, 0, 7, 0, 0, 9, -2, 0);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) for (int k = 0; k < N; k++) set_req(k, 0, 1, 0, 0, k + 2, 0, 0);
      settle();
      if (c < 3) begin
        total++;
        if (o_req_ready !== want_g[c])
          begin bad++; $display("FAIL wrap_grant c=%0d got=%b want=%b", c, o_req_ready, want_g[c]); end
      end
      if (m2_v) begin
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {1'b1, 2'(m2_id), m2_p})
          begin bad++; $display("FAIL wrap_rsp c=%0d got v=%b id=%0d d=%h want id=%0d d=%h",
                   c, o_rsp_valid, o_rsp_id, o_rsp_data, m2_id, m2_p); end
      end
      tick();
    end
  endtask

  task automatic test_sign();
    do_reset();
    rdy_v = 1'b1;
    set_req(2, 1, 1, 0, 0, 1, 2, 0);
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c == 2) begin
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {1'b1, 2'd2, 32'hC0800000})
          begin bad++; $display("FAIL sign_rsp got v=%b id=%0d d=%h want v=1 id=2 d=c0800000",
                   o_rsp_valid, o_rsp_id, o_rsp_data); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rdy_v = 1'b0;
    set_req(0, 0, 3, 0, 0, 3, 0, 0);
    set_req(1, 0, 5, 0, 0, 5, 0, 0);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) rst_v = 1'b1;
      if (c == 3) begin
        rst_v = 1'b0;
        rdy_v = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 0, k + 1, 0, 0, 3, 0, 0);
      end
      settle();
      if (c == 2) begin
        total++;
        if ({o_busy, o_req_ready} !== {1'b1, 4'b0000})
          begin bad++; $display("FAIL mid_pre got busy=%b ready=%b want busy=1 ready=0000", o_busy, o_req_ready); end
      end
      if (c == 3) begin
        total++;
        if ({o_rsp_valid, o_busy, o_req_ready} !== {1'b0, 1'b0, 4'b0001})
          begin bad++; $display("FAIL mid_after got v=%b busy=%b ready=%b want 0/0/0001",
                   o_rsp_valid, o_busy, o_req_ready); end
      end
      if (c >= 3) begin
        total++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_data} !== {m2_v, m2_v ? {2'(m2_id), m2_p} : {o_rsp_id, o_rsp_data}})
          begin bad++; $display("FAIL mid_rsp c=%0d got v=%b id=%0d d=%h want v=%b id=%0d d=%h",
                   c, o_rsp_valid, o_rsp_id, o_rsp_data, m2_v, m2_id, m2_p); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!rq_v[k] && $urandom_range(0, 2) == 0)
          set_req(k, 1'($urandom_range(0, 1)), int'($urandom_range(1, 15)), int'($urandom_range(0, 20)) - 10,
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 15)), int'($urandom_range(0, 20)) - 10, 0);
      end
      rdy_v = ($urandom_range(0, 3) != 0);
      settle();
      total++;
      if ({o_req_ready, o_rsp_valid, o_busy} !== {exp_ready, m2_v, m1_v | m2_v})
        begin bad++; $display("FAIL rand_ctl c=%0d got=%b/%b/%b want=%b/%b/%b", c,
                 o_req_ready, o_rsp_valid, o_busy, exp_ready, m2_v, m1_v | m2_v); end
      if (m2_v) begin
        total++;
        if ({o_rsp_id, o_rsp_data} !== {2'(m2_id), m2_p})
          begin bad++; $display("FAIL rand_rsp c=%0d got id=%0d d=%h want id=%0d d=%h",
                   c, o_rsp_id, o_rsp_data, m2_id, m2_p); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; rr = 1'b0; dv = '0; da = '0; db = '0;
    rst_v = 1'b1; rdy_v = 1'b0;
    m1_v = 0; m2_v = 0; m1_id = 0; m2_id = 0; m1_p = '0; m2_p = '0; m_ptr = 0; g = -1;
    for (int k = 0; k < N; k++) begin
      rq_v[k] = 0; rq_hold[k] = 0; rq_a[k] = '0; rq_b[k] = '0; rq_p[k] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_sign();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
